alu_issue_wb: RTL and testbench
===============================

Name: alu_issue_wb

Overview:
Sequencing stage wrapped around the 16-bit combinational ALU (ALUhardware: A, B, carry-in, 3-bit opcode → W, zero, neg).
- Accepts instructions over a valid/ready handshake.
- Reads operands from an internal register file and drives them into the ALU as registered signals.
- Captures W/zero/neg and writes the result back into the register file and flag registers.
- Also has a direct load port for initialising registers.

Parameters:
- WIDTH, 16, datapath width; must match the ALU.
- NREG, 8, number of registers (address width = log2(NREG) = 3).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_valid  in  1  register-load request.
- ld_ready  out  1  high in IDLE only.
- ld_addr  in  3  load target register.
- ld_data  in  WIDTH  load value.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  = (state==IDLE) & ~ld_valid.
- instr_op  in  3  ALU opcode.
- instr_rd  in  3  destination register.
- instr_rs  in  3  source A register.
- instr_rt  in  3  source B register.
- instr_cin  in  1  carry-in for this instruction.
- alu_a  out  WIDTH  registered operand A to ALU.
- alu_b  out  WIDTH  registered operand B to ALU.
- alu_cin  out  1  registered carry-in to ALU.
- alu_opcode  out  3  registered opcode to ALU.
- alu_w  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_neg  in  1  ALU negative flag.
- done  out  1  one-cycle pulse after writeback.
- result  out  WIDTH  last written-back value.
- flag_z  out  1  last captured zero flag.
- flag_n  out  1  last captured neg flag.
- dbg_addr  in  3  debug read address.
- dbg_data  out  WIDTH  combinational read of R[dbg_addr].

Behaviour:
- Reset (synchronous, rst high at an edge):
  - state=IDLE; all R[i]=0; alu_a/alu_b/alu_opcode/alu_cin=0; result=0; flag_z=0; flag_n=0; done=0.
  - Reset mid-instruction aborts it: no writeback, no done.
- R0 is hardwired zero: reads return 0; writes to R0 (load or writeback) are discarded.
- FSM states: IDLE → READ → EXEC → IDLE.
- IDLE:
  - If ld_valid: R[ld_addr]<=ld_data (unless addr 0); stay IDLE. Load has priority over an instruction in the same cycle.
  - Else if instr_valid: latch op/rd/rs/rt/cin; go READ.
- READ: alu_a<=R[rs], alu_b<=R[rt], alu_opcode<=op, alu_cin<=cin; go EXEC.
- EXEC (ALU inputs stable a full cycle): at the edge, R[rd]<=alu_w, result<=alu_w, flag_z<=alu_zero, flag_n<=alu_neg; done<=1; go IDLE.
- done is high exactly for the first IDLE cycle after EXEC, otherwise 0.
- Latency: handshake at edge k → ALU operands valid after edge k+1 → writeback at edge k+2 → done high in cycle k+2..k+3.
- Throughput: one instruction per 3 cycles; a back-to-back instruction can be accepted in the same cycle done is high.
- Hazards: instructions are fully serialised, so rd of instruction n is visible to rs/rt of instruction n+1 with no stall.
- alu_* outputs hold their last values in IDLE; they change only in READ.
- ld_valid outside IDLE is ignored (ld_ready=0); it is not queued.
- Instruction fields are sampled only at the handshake; later changes on instr_* have no effect.
- rd==rs==rt is legal: operands are read before the write.
- Arithmetic is performed solely by the ALU; this block applies no width extension and no wrap handling.

Test Plan (bench ALU stub: opcode 0 returns W=A+B+cin, zero=(W==0), neg=W[15]):
- Reset: rst high 2 cycles → all outputs 0, instr_ready=1, dbg_data=0 for every address.
- Load + add: load R1=2235, R2=100; instr op0 rd3 rs1 rt2 cin1 → alu_a=2235 and alu_b=100 one cycle after accept; done after 3 cycles; R3=2336, flag_z=0, flag_n=0.
- Wrap and flags: R1=16'hFFFF, R2=0, cin=1, rd4 → R4=0, flag_z=1. Then R1=16'h7FFF, R2=1, cin=0 → result=16'h8000, flag_n=1.
- R0 and priority: load R0=5 → dbg R0=0. Assert ld_valid and instr_valid together in IDLE → load performed, instr_ready=0, instruction accepted the next cycle.
- Back-to-back dependency: instr A writes R3; instr B uses rs=3, offered continuously → B accepted in A's done cycle and sees A's result in alu_a.
- Reset mid-op: rst asserted during EXEC → R[rd] unchanged (still 0), done never pulses, state IDLE next cycle.

Source files
------------

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: sequencing stage around a 16-bit combinational ALU.
// Instructions are accepted over valid/ready, and their operands are read from
// an internal register file. The operands are presented to the ALU for a full
// cycle, then the result and flags are written back. Instructions are fully
// serialised (IDLE -> READ -> EXEC), so no hazard logic is needed.
module alu_issue_wb #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AW-1:0]     ld_addr,
    input  logic [WIDTH-1:0]  ld_data,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [AW-1:0]     instr_rd,
    input  logic [AW-1:0]     instr_rs,
    input  logic [AW-1:0]     instr_rt,
    input  logic              instr_cin,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_cin,
    output logic [2:0]        alu_opcode,
    input  logic [WIDTH-1:0]  alu_w,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              flag_z,
    output logic              flag_n,
    input  logic [AW-1:0]     dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] rf [NREG];

    // Instruction fields captured at the handshake
    logic [2:0]    op_p0;
    logic [AW-1:0] rd_p0;
    logic [AW-1:0] rs_p0;
    logic [AW-1:0] rt_p0;
    logic          cin_p0;

    logic instr_fire;
    logic ld_fire;

    // R0 reads as zero regardless of array contents
    function automatic logic [WIDTH-1:0] rf_read(input logic [AW-1:0] a);
        if (a == '0) begin
            return '0;
        end
        return rf[a];
    endfunction

    assign instr_fire = instr_valid & instr_ready;
    assign ld_fire    = ld_valid & ld_ready;
    assign dbg_data   = rf_read(dbg_addr);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a load in IDLE blocks instruction acceptance
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_fire) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs: loads win over instructions in the same IDLE cycle
    always_comb begin
        ld_ready    = (state == IDLE);
        instr_ready = (state == IDLE) && !ld_valid;
    end

    // ---- stage p0: capture instruction fields at the handshake ----
    always_ff @(posedge clk) begin
        if (instr_fire) begin
            op_p0  <= instr_op;
            rd_p0  <= instr_rd;
            rs_p0  <= instr_rs;
            rt_p0  <= instr_rt;
            cin_p0 <= instr_cin;
        end
    end

    // ---- stage p1: drive registered operands into the ALU; they hold outside READ ----
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_opcode <= '0;
        end else if (state == READ) begin
            alu_a      <= rf_read(rs_p0);
            alu_b      <= rf_read(rt_p0);
            alu_cin    <= cin_p0;
            alu_opcode <= op_p0;
        end
    end

    // Register file: loads in IDLE, writeback at the end of EXEC; R0 writes dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (ld_fire && (ld_addr != '0)) begin
            rf[ld_addr] <= ld_data;
        end else if ((state == EXEC) && (rd_p0 != '0)) begin
            rf[rd_p0] <= alu_w;
        end
    end

    // ---- stage p2: capture ALU result and flags at the end of EXEC ----
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == EXEC) begin
            result <= alu_w;
            flag_z <= alu_zero;
            flag_n <= alu_neg;
        end
    end

    // done marks the first IDLE cycle after a completed writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == EXEC);
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Testbench for alu_issue_wb: directed stimulus, a transaction-level model
// checked every cycle, and hand-computed literal expectations.
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [2:0]  instr_rd;
    logic [2:0]  instr_rs;
    logic [2:0]  instr_rt;
    logic        instr_cin;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_w;
    logic        alu_zero;
    logic        alu_neg;
    logic        done;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_n;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    alu_issue_wb #(.WIDTH(16), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_cin(instr_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
        .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .done(done), .result(result), .flag_z(flag_z), .flag_n(flag_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Bench ALU: op0 = A+B+cin, op1 = A&B, others = A^B
    function automatic logic [15:0] spec_alu(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic [2:0] op);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        if (op == 3'd0) return s[15:0];
        if (op == 3'd1) return a & b;
        return a ^ b;
    endfunction

    always_comb begin
        alu_w    = spec_alu(alu_a, alu_b, alu_cin, alu_opcode);
        alu_zero = (alu_w == 16'd0);
        alu_neg  = alu_w[15];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: age -1 = no instruction in flight, 0 = just accepted,
    // 1 = operands presented, writeback on the following edge.
    logic [15:0] m_reg [8];
    int          m_age;
    logic [2:0]  m_op, m_rd, m_rs, m_rt;
    logic        m_cin;
    logic [15:0] exp_a, exp_b, exp_res, m_w;
    logic [2:0]  exp_op;
    logic        exp_cin, exp_z, exp_n, exp_done;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
            m_age = -1;
            exp_a = 0; exp_b = 0; exp_op = 0; exp_cin = 0;
            exp_res = 0; exp_z = 0; exp_n = 0; exp_done = 0;
        end else begin
            exp_done = 1'b0;
            if (m_age == 1) begin
                m_w = spec_alu(exp_a, exp_b, exp_cin, exp_op);
                if (m_rd != 3'd0) m_reg[m_rd] = m_w;
                exp_res  = m_w;
                exp_z    = (m_w == 16'd0);
                exp_n    = m_w[15];
                exp_done = 1'b1;
                m_age    = -1;
            end else if (m_age == 0) begin
                exp_a   = m_reg[m_rs];
                exp_b   = m_reg[m_rt];
                exp_op  = m_op;
                exp_cin = m_cin;
                m_age   = 1;
            end else if (ld_valid) begin
                if (ld_addr != 3'd0) m_reg[ld_addr] = ld_data;
            end else if (instr_valid) begin
                m_op = instr_op; m_rd = instr_rd; m_rs = instr_rs;
                m_rt = instr_rt; m_cin = instr_cin;
                m_age = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("ld_ready",    ld_ready,    m_age == -1);
            check("instr_ready", instr_ready, (m_age == -1) && !ld_valid);
            check("done",        done,        exp_done);
            check("result",      result,      exp_res);
            check("flag_z",      flag_z,      exp_z);
            check("flag_n",      flag_n,      exp_n);
            check("alu_a",       alu_a,       exp_a);
            check("alu_b",       alu_b,       exp_b);
            check("alu_cin",     alu_cin,     exp_cin);
            check("alu_opcode",  alu_opcode,  exp_op);
            check("dbg_data",    dbg_data,    m_reg[dbg_addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        dbg_addr = dbg_addr + 3'd1;
    endtask

    task automatic peek(input string name, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
    endtask

    task automatic do_load(input logic [2:0] a, input logic [15:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 1'b0;
        ld_addr = 3'($urandom); ld_data = 16'($urandom);
    endtask

    // Offer an instruction until accepted, then scramble the fields
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic cin);
        int n;
        n = 0;
        instr_valid = 1'b1; instr_op = op; instr_rd = rd;
        instr_rs = rs; instr_rt = rt; instr_cin = cin;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!instr_ready) check("accept_timeout", 0, 1);
        tick();
        instr_valid = 1'b0;
        instr_op = 3'($urandom); instr_rd = 3'($urandom);
        instr_rs = 3'($urandom); instr_rt = 3'($urandom); instr_cin = 1'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 10);
        check("done_seen", done, 1);
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_addr = 0; ld_data = 0;
        instr_valid = 1'b0; instr_op = 0; instr_rd = 0; instr_rs = 0;
        instr_rt = 0; instr_cin = 0; dbg_addr = 0;

        // Reset
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_alu_a", alu_a, 0);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_instr_ready", instr_ready, 1);
        for (int i = 0; i < 8; i++) peek("rst_reg", 3'(i), 16'd0);

        // Load + add
        do_load(3'd1, 16'd2235);
        do_load(3'd2, 16'd100);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b1);
        tick();
        check("add_alu_a", alu_a, 2235);
        check("add_alu_b", alu_b, 100);
        tick();
        check("add_done", done, 1);
        check("add_result", result, 2336);
        check("add_flag_z", flag_z, 0);
        check("add_flag_n", flag_n, 0);
        peek("add_r3", 3'd3, 16'd2336);

        // Wrap to zero
        do_load(3'd1, 16'hFFFF);
        do_load(3'd2, 16'h0000);
        issue(3'd0, 3'd4, 3'd1, 3'd2, 1'b1);
        wait_done();
        check("wrap_result", result, 0);
        check("wrap_flag_z", flag_z, 1);
        peek("wrap_r4", 3'd4, 16'd0);

        // Negative result
        do_load(3'd1, 16'h7FFF);
        do_load(3'd2, 16'h0001);
        issue(3'd0, 3'd5, 3'd1, 3'd2, 1'b0);
        wait_done();
        check("neg_result", result, 16'h8000);
        check("neg_flag_n", flag_n, 1);
        check("neg_flag_z", flag_z, 0);

        // R0 hardwired zero: load and writeback both dropped
        do_load(3'd0, 16'd5);
        peek("r0_load", 3'd0, 16'd0);
        issue(3'd0, 3'd0, 3'd1, 3'd2, 1'b0);
        wait_done();
        check("r0_wb_result", result, 16'h8000);
        peek("r0_wb", 3'd0, 16'd0);

        // Load has priority over a simultaneous instruction
        ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'd77;
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 3'd7;
        instr_rs = 3'd6; instr_rt = 3'd6; instr_cin = 1'b0;
        #1;
        check("prio_ready_low", instr_ready, 0);
        tick();
        ld_valid = 1'b0;
        #1;
        check("prio_ready_high", instr_ready, 1);
        peek("prio_r6", 3'd6, 16'd77);
        tick();
        instr_valid = 1'b0;
        wait_done();
        peek("prio_r7", 3'd7, 16'd154);

        // Back-to-back dependency: B offered continuously, uses A's rd
        do_load(3'd1, 16'd10);
        do_load(3'd2, 16'd20);
        instr_valid = 1'b1; instr_op = 3'd0; instr_rd = 3'd3;
        instr_rs = 3'd1; instr_rt = 3'd2; instr_cin = 1'b0;
        tick();
        instr_rd = 3'd5; instr_rs = 3'd3; instr_rt = 3'd1;
        wait_done();
        check("b2b_ready_in_done", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        tick();
        check("b2b_alu_a", alu_a, 30);
        check("b2b_alu_b", alu_b, 10);
        wait_done();
        peek("b2b_r5", 3'd5, 16'd40);

        // Reset during EXEC aborts the instruction
        issue(3'd0, 3'd4, 3'd1, 3'd2, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_done", done, 0);
        check("abort_ready", instr_ready, 1);
        peek("abort_r4", 3'd4, 16'd0);
        tick(); tick(); tick();
        check("abort_done_later", done, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
